// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: widths, the NOP encoding and the fetch response layout.
package mips_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH  = 32;

  localparam logic [INSTR_WIDTH-1:0] MIPS_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   error;
  } fetch_rsp_t;

  localparam int unsigned FETCH_RSP_WIDTH = $bits(fetch_rsp_t);

endpackage

// File: rtl/fetch_rsp_fifo.sv
// Two-entry response FIFO; the head register drives the outputs and keeps its
// last value once the FIFO has drained.
module fetch_rsp_fifo #(
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && (r_count != 2'd2);
  assign w_pop   = i_pop  && (r_count != 2'd0);
  assign o_dout  = r_head;
  assign o_count = r_count;

  // Pop shifts the tail into the head, so the head is always the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_din;
          else                 r_tail <= i_din;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) r_head <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_din;
          end else begin
            r_head <= r_tail;
            r_tail <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_responder.sv
// Instruction memory responder with a 2-deep response buffer.
// Optional FETCH_STATS_EN adds the fetch_count accepted-request counter.
module instr_fetch_responder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_instr,
  output logic [ADDR_WIDTH-1:0]          rsp_addr,
  output logic                           rsp_error,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_index,
  input  logic [DATA_WIDTH-1:0]          load_data
`ifdef FETCH_STATS_EN
  ,output logic [31:0]                   fetch_count
`endif
);

  import mips_pkg::*;

  localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
  localparam int unsigned ENTRY_W = DATA_WIDTH + ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [ADDR_WIDTH-3:0] w_word;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_instr;
  logic [ENTRY_W-1:0]    w_din;
  logic [ENTRY_W-1:0]    w_head;
  logic [1:0]            w_count;
  logic                  w_push;
  logic                  w_pop;

  assign w_word = req_addr[ADDR_WIDTH-1:2];
  assign w_err  = (req_addr[1:0] != 2'b00) ||
                  (ADDR_WIDTH'(w_word) >= ADDR_WIDTH'(DEPTH_WORDS));

  // Combinational read of the pre-edge contents gives read-before-write on collisions.
  always_comb begin
    w_instr = DATA_WIDTH'(MIPS_NOP);
    if (!w_err) w_instr = r_mem[w_word[IDX_W-1:0]];
  end

  always_ff @(posedge clock) begin
    if (load_en) r_mem[load_index] <= load_data;
  end

  assign req_ready = (w_count < 2'd2);
  assign rsp_valid = (w_count != 2'd0);
  assign w_push    = req_valid && req_ready;
  assign w_pop     = rsp_valid && rsp_ready;
  assign w_din     = {w_instr, req_addr, w_err};

  fetch_rsp_fifo #(
    .WIDTH (ENTRY_W)
  ) u_rsp_fifo (
    .clk     (clock),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_head),
    .o_count (w_count)
  );

  assign {rsp_instr, rsp_addr, rsp_error} = w_head;

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    r_fetch_count <= '0;
    else if (w_push) r_fetch_count <= r_fetch_count + 32'd1;
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Scoreboarded bench for instr_fetch_responder; checks fetch_count when FETCH_STATS_EN is set.
module tb_instr_fetch_responder;

  localparam int DEPTH = 256;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_error;
  logic        load_en;
  logic [7:0]  load_index;
  logic [31:0] load_data;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
`endif

  always #5 clock = ~clock;

  instr_fetch_responder #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_instr  (rsp_instr),
    .rsp_addr   (rsp_addr),
    .rsp_error  (rsp_error),
    .load_en    (load_en),
    .load_index (load_index),
    .load_data  (load_data)
`ifdef FETCH_STATS_EN
    ,.fetch_count(fetch_count)
`endif
  );

  exp_t        sb[$];
  exp_t        got[$];
  logic [31:0] m_mem [DEPTH];
  int          m_count;
  logic [31:0] m_fc;
  bit          last_acc;
  bit          mon_en;
  int          errors;
  int          checks;

  // Reference model and scoreboard, sampled on the falling edge.
  always @(negedge clock) begin
    bit          acc;
    bit          pop;
    exp_t        e;
    exp_t        h;
    int unsigned idx;
    if (mon_en && reset_n) begin
      checks++;
      if (req_ready !== (m_count < 2)) begin
        errors++;
        $display("FAIL req_ready: got %b want %b", req_ready, (m_count < 2));
      end
      checks++;
      if (rsp_valid !== (m_count > 0)) begin
        errors++;
        $display("FAIL rsp_valid: got %b want %b", rsp_valid, (m_count > 0));
      end
      if (m_count > 0) begin
        h = sb[0];
        checks++;
        if ({rsp_instr, rsp_addr, rsp_error} !== h) begin
          errors++;
          $display("FAIL rsp_head: got instr=%h addr=%h err=%b want instr=%h addr=%h err=%b",
                   rsp_instr, rsp_addr, rsp_error, h.instr, h.addr, h.err);
        end
      end
`ifdef FETCH_STATS_EN
      checks++;
      if (fetch_count !== m_fc) begin
        errors++;
        $display("FAIL fetch_count: got %0d want %0d", fetch_count, m_fc);
      end
`endif
      acc = req_valid && (m_count < 2);
      pop = rsp_ready && (m_count > 0);
      if (pop) begin
        got.push_back({rsp_instr, rsp_addr, rsp_error});
        void'(sb.pop_front());
      end
      if (acc) begin
        idx     = req_addr[31:2];
        e.addr  = req_addr;
        e.err   = (req_addr[1:0] != 2'b00) || (idx >= DEPTH);
        e.instr = e.err ? 32'h0 : m_mem[idx];
        sb.push_back(e);
        m_fc = m_fc + 32'd1;
      end
      if (load_en) m_mem[load_index] = load_data;
      m_count = m_count + int'(acc) - int'(pop);
      last_acc = acc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    sb.delete();
    m_count  = 0;
    m_fc     = '0;
    last_acc = 1'b0;
  endtask

  task automatic send(input logic [31:0] addr);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_addr  = addr;
    do begin
      tick(1);
      n++;
    end while (!last_acc && n < 64);
    checks++;
    if (!last_acc) begin
      errors++;
      $display("FAIL send_timeout: addr=%h not accepted after %0d cycles, want accept", addr, n);
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_count > 0 && n < 64) begin
      tick(1);
      n++;
    end
    checks++;
    if (m_count != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses left, want 0", m_count);
    end
  endtask

  task automatic load_word(input logic [7:0] idx, input logic [31:0] data);
    load_en    = 1'b1;
    load_index = idx;
    load_data  = data;
    tick(1);
    load_en    = 1'b0;
  endtask

  task automatic check_got(input string name, input int i, input exp_t want);
    checks++;
    if (got.size() <= i) begin
      errors++;
      $display("FAIL %s: only %0d responses, want index %0d", name, got.size(), i);
    end else if (got[i] !== want) begin
      errors++;
      $display("FAIL %s: got instr=%h addr=%h err=%b want instr=%h addr=%h err=%b",
               name, got[i].instr, got[i].addr, got[i].err, want.instr, want.addr, want.err);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    load_en   = 1'b0;
    load_index = '0;
    load_data = '0;
    tick(3);
    model_clear();
    reset_n = 1'b1;
    mon_en  = 1'b1;
    tick(1);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++;
    if ({rsp_instr, rsp_addr, rsp_error} !== 65'd0) begin
      errors++;
      $display("FAIL reset_rsp_fields: got instr=%h addr=%h err=%b want zeros", rsp_instr, rsp_addr, rsp_error);
    end
`ifdef FETCH_STATS_EN
    checks++;
    if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_fetch_count: got %0d want 0", fetch_count); end
`endif
  endtask

  task automatic test_basic();
    load_word(8'd0, 32'h2008_0005);
    load_word(8'd1, 32'h2009_0003);
    load_word(8'd2, 32'h8C0A_0000);
    load_word(8'd3, 32'h0109_5020);
    rsp_ready = 1'b1;
    got.delete();
    send(32'h0);
    send(32'h4);
    drain();
    check_got("basic_w0", 0, '{32'h2008_0005, 32'h0, 1'b0});
    check_got("basic_w1", 1, '{32'h2009_0003, 32'h4, 1'b0});
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    got.delete();
    fork
      begin
        send(32'h0);
        send(32'h4);
        send(32'h8);
      end
      begin
        tick(4);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready: got %b want 0", req_ready); end
        checks++;
        if (rsp_addr !== 32'h0) begin errors++; $display("FAIL bp_head_stable: got %h want 00000000", rsp_addr); end
        rsp_ready = 1'b1;
      end
    join
    drain();
    check_got("bp_first",  0, '{32'h2008_0005, 32'h0, 1'b0});
    check_got("bp_second", 1, '{32'h2009_0003, 32'h4, 1'b0});
    check_got("bp_third",  2, '{32'h8C0A_0000, 32'h8, 1'b0});
  endtask

  task automatic test_errors();
    rsp_ready = 1'b1;
    got.delete();
    send(32'h2);
    send(32'h400);
    send(32'h4);
    drain();
    check_got("err_misaligned", 0, '{32'h0, 32'h2, 1'b1});
    check_got("err_range",      1, '{32'h0, 32'h400, 1'b1});
    check_got("err_recover",    2, '{32'h2009_0003, 32'h4, 1'b0});
  endtask

  task automatic test_push_pop();
    logic [31:0] addrs [3];
    addrs[0] = 32'h4;
    addrs[1] = 32'h8;
    addrs[2] = 32'hC;
    rsp_ready = 1'b1;
    got.delete();
    send(32'h0);
    for (int i = 0; i < 3; i++) begin
      send(addrs[i]);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b1 || rsp_addr !== addrs[i]) begin
        errors++;
        $display("FAIL pushpop_head: got valid=%b ready=%b addr=%h want 1 1 %h",
                 rsp_valid, req_ready, rsp_addr, addrs[i]);
      end
    end
    drain();
    check_got("pushpop_last", 3, '{32'h0109_5020, 32'hC, 1'b0});
  endtask

  task automatic test_load_collision();
    rsp_ready = 1'b1;
    got.delete();
    load_en    = 1'b1;
    load_index = 8'd3;
    load_data  = 32'hDEAD_BEEF;
    send(32'hC);
    load_en = 1'b0;
    send(32'hC);
    drain();
    check_got("collide_old", 0, '{32'h0109_5020, 32'hC, 1'b0});
    check_got("collide_new", 1, '{32'hDEAD_BEEF, 32'hC, 1'b0});
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    send(32'h0);
    send(32'h4);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_rsp_valid: got %b want 0", rsp_valid); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL midreset_req_ready: got %b want 1", req_ready); end
`ifdef FETCH_STATS_EN
    checks++;
    if (fetch_count !== 32'd0) begin errors++; $display("FAIL midreset_fetch_count: got %0d want 0", fetch_count); end
`endif
    tick(1);
    model_clear();
    reset_n = 1'b1;
    tick(1);
    rsp_ready = 1'b1;
    got.delete();
    send(32'h0);
    send(32'h4);
    send(32'h8);
    send(32'hC);
    send(32'h0);
    drain();
    check_got("after_reset_w0", 0, '{32'h2008_0005, 32'h0, 1'b0});
    check_got("after_reset_w3", 3, '{32'hDEAD_BEEF, 32'hC, 1'b0});
`ifdef FETCH_STATS_EN
    checks++;
    if (fetch_count !== 32'd5) begin errors++; $display("FAIL fetch_count_5: got %0d want 5", fetch_count); end
`endif
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    mon_en  = 1'b0;
    m_count = 0;
    m_fc    = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_push_pop();
    test_load_collision();
    test_reset_mid();
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
